// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer and its return stack.
package pc_sequencer_pkg;

    localparam int unsigned PC_W_DEF  = 11;
    localparam int unsigned OFF_W_DEF = 10;
    localparam int unsigned DEPTH_DEF = 4;
    localparam int unsigned DEPTH_W   = 3;

    typedef enum logic [1:0] {
        OP_NEXT = 2'b00,
        OP_JUMP = 2'b01,
        OP_CALL = 2'b10,
        OP_RET  = 2'b11
    } op_code_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_WAIT  = 2'b01,
        ST_FAULT = 2'b10
    } state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Op handshake plus return-stack (BSR) strobe/data bundle.
interface pc_sequencer_if
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned PC_W  = PC_W_DEF,
    parameter int unsigned OFF_W = OFF_W_DEF
);

    logic             op_valid;
    logic [1:0]       op_code;
    logic [OFF_W-1:0] op_offset;
    logic             op_ready;
    logic             bsr_enable;
    logic             bsr_branch;
    logic             bsr_return;
    logic [OFF_W-1:0] bsr_s;
    logic [PC_W-1:0]  bsr_old_pc;
    logic [PC_W-1:0]  bsr_new_pc;

    // Op issuer and return stack side
    modport master (
        output op_valid, op_code, op_offset, bsr_new_pc,
        input  op_ready, bsr_enable, bsr_branch, bsr_return, bsr_s, bsr_old_pc
    );

    // Sequencer side
    modport slave (
        input  op_valid, op_code, op_offset, bsr_new_pc,
        output op_ready, bsr_enable, bsr_branch, bsr_return, bsr_s, bsr_old_pc
    );

endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: issues one control-flow op at a time, drives the
// return stack strobes and tracks call depth, faulting on over/underflow.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned PC_W  = PC_W_DEF,
    parameter int unsigned OFF_W = OFF_W_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic               clk,
    input  logic               reset,
    pc_sequencer_if.slave      bus,
    output logic [PC_W-1:0]    pc,
    output logic [DEPTH_W-1:0] depth,
    output logic               fault
);

    state_e             state, next_state;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               fault_q, fault_d;
    logic               branch_q, branch_d;
    logic               return_q, return_d;
    logic [OFF_W-1:0]   s_q, s_d;
    logic [PC_W-1:0]    old_q, old_d;
    logic               ready_q;
    logic               enable_q;

    // State and datapath registers; a strobe in flight is dropped on reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_RUN;
            pc_q     <= '0;
            depth_q  <= '0;
            fault_q  <= 1'b0;
            branch_q <= 1'b0;
            return_q <= 1'b0;
            s_q      <= '0;
            old_q    <= '0;
            ready_q  <= 1'b1;
            enable_q <= 1'b1;
        end else begin
            state    <= next_state;
            pc_q     <= pc_d;
            depth_q  <= depth_d;
            fault_q  <= fault_d;
            branch_q <= branch_d;
            return_q <= return_d;
            s_q      <= s_d;
            old_q    <= old_d;
            ready_q  <= (next_state == ST_RUN);
            enable_q <= (next_state != ST_FAULT);
        end
    end

    // Next-state and datapath update; WAIT spans the strobe cycle and the load cycle
    always_comb begin
        next_state = state;
        pc_d       = pc_q;
        depth_d    = depth_q;
        fault_d    = fault_q;
        branch_d   = 1'b0;
        return_d   = 1'b0;
        s_d        = s_q;
        old_d      = old_q;
        unique case (state)
            ST_RUN: begin
                if (bus.op_valid) begin
                    unique case (op_code_e'(bus.op_code))
                        OP_NEXT: pc_d = pc_q + PC_W'(1);
                        OP_JUMP: pc_d = pc_q + PC_W'(bus.op_offset);
                        OP_CALL: begin
                            if (depth_q < DEPTH_W'(DEPTH)) begin
                                branch_d   = 1'b1;
                                old_d      = pc_q;
                                s_d        = bus.op_offset;
                                depth_d    = depth_q + DEPTH_W'(1);
                                next_state = ST_WAIT;
                            end else begin
                                fault_d    = 1'b1;
                                next_state = ST_FAULT;
                            end
                        end
                        OP_RET: begin
                            if (depth_q != '0) begin
                                return_d   = 1'b1;
                                depth_d    = depth_q - DEPTH_W'(1);
                                next_state = ST_WAIT;
                            end else begin
                                fault_d    = 1'b1;
                                next_state = ST_FAULT;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_WAIT: begin
                // Strobe cycle still in progress: the stack answers on the next cycle
                if (!(branch_q || return_q)) begin
                    pc_d       = bus.bsr_new_pc;
                    next_state = ST_RUN;
                end
            end
            ST_FAULT: ;
            default: next_state = ST_FAULT;
        endcase
    end

    assign pc             = pc_q;
    assign depth          = depth_q;
    assign fault          = fault_q;
    assign bus.op_ready   = ready_q;
    assign bus.bsr_enable = enable_q;
    assign bus.bsr_branch = branch_q;
    assign bus.bsr_return = return_q;
    assign bus.bsr_s      = s_q;
    assign bus.bsr_old_pc = old_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with a behavioural return stack alongside.
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    localparam int unsigned PC_W  = 11;
    localparam int unsigned OFF_W = 10;
    localparam int unsigned DEPTH = 4;

    logic               clk;
    logic               reset;
    logic [PC_W-1:0]    pc;
    logic [DEPTH_W-1:0] depth;
    logic               fault;
    int                 n_vec;
    int                 n_err;

    pc_sequencer_if #(.PC_W(PC_W), .OFF_W(OFF_W)) bus ();

    pc_sequencer #(.PC_W(PC_W), .OFF_W(OFF_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .pc    (pc),
        .depth (depth),
        .fault (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Return stack model: shift register with no reset, answer one clock after the strobe
    logic [PC_W-1:0] stk [DEPTH];
    logic [PC_W-1:0] new_pc_r;
    initial begin
        new_pc_r = '0;
        for (int i = 0; i < DEPTH; i++) stk[i] = '0;
    end
    always @(posedge clk) begin
        if (bus.bsr_enable) begin
            if (bus.bsr_branch) begin
                stk[0] <= bus.bsr_old_pc;
                for (int i = 1; i < DEPTH; i++) stk[i] <= stk[i-1];
                new_pc_r <= bus.bsr_old_pc + PC_W'(bus.bsr_s);
            end else if (bus.bsr_return) begin
                new_pc_r <= stk[0] + PC_W'(1);
                for (int i = 0; i < DEPTH - 1; i++) stk[i] <= stk[i+1];
            end
        end
    end
    assign bus.bsr_new_pc = new_pc_r;

    // Offer one op for one cycle; returns #1 after the accepting edge
    task automatic issue(input logic [1:0] code, input logic [OFF_W-1:0] off);
        bus.op_valid  = 1'b1;
        bus.op_code   = code;
        bus.op_offset = off;
        @(posedge clk); #1;
        bus.op_valid  = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        n_vec++; if (pc !== 11'h000) begin n_err++; $display("FAIL reset_pc got=%h want=000", pc); end
        n_vec++; if (depth !== 3'd0) begin n_err++; $display("FAIL reset_depth got=%0d want=0", depth); end
        n_vec++; if (fault !== 1'b0) begin n_err++; $display("FAIL reset_fault got=%b want=0", fault); end
        n_vec++; if (bus.op_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready got=%b want=1", bus.op_ready); end
        n_vec++; if (bus.bsr_enable !== 1'b1) begin n_err++; $display("FAIL reset_enable got=%b want=1", bus.bsr_enable); end
        n_vec++; if ({bus.bsr_branch, bus.bsr_return} !== 2'b00) begin n_err++; $display("FAIL reset_strobes got=%b want=00", {bus.bsr_branch, bus.bsr_return}); end
        n_vec++; if (bus.bsr_s !== 10'h000 || bus.bsr_old_pc !== 11'h000) begin n_err++; $display("FAIL reset_operands got s=%h old=%h want 000/000", bus.bsr_s, bus.bsr_old_pc); end
    endtask

    task automatic test_next();
        logic [PC_W-1:0] exp_pc [3];
        exp_pc[0] = 11'h001; exp_pc[1] = 11'h002; exp_pc[2] = 11'h003;
        for (int i = 0; i < 3; i++) begin
            issue(2'(OP_NEXT), 10'h000);
            n_vec++; if (pc !== exp_pc[i]) begin n_err++; $display("FAIL next_pc[%0d] got=%h want=%h", i, pc, exp_pc[i]); end
            n_vec++; if (bus.op_ready !== 1'b1) begin n_err++; $display("FAIL next_ready[%0d] got=%b want=1", i, bus.op_ready); end
        end
        n_vec++; if (depth !== 3'd0) begin n_err++; $display("FAIL next_depth got=%0d want=0", depth); end
    endtask

    task automatic test_call_ret();
        issue(2'(OP_JUMP), 10'h00D);
        n_vec++; if (pc !== 11'h010) begin n_err++; $display("FAIL jump_pc got=%h want=010", pc); end
        issue(2'(OP_CALL), 10'h020);
        n_vec++; if (bus.bsr_branch !== 1'b1 || bus.bsr_return !== 1'b0) begin n_err++; $display("FAIL call_strobe got b=%b r=%b want 1/0", bus.bsr_branch, bus.bsr_return); end
        n_vec++; if (bus.bsr_old_pc !== 11'h010 || bus.bsr_s !== 10'h020) begin n_err++; $display("FAIL call_operands got old=%h s=%h want 010/020", bus.bsr_old_pc, bus.bsr_s); end
        n_vec++; if (bus.op_ready !== 1'b0 || depth !== 3'd1) begin n_err++; $display("FAIL call_n1 got ready=%b depth=%0d want 0/1", bus.op_ready, depth); end
        step();
        n_vec++; if (bus.bsr_branch !== 1'b0 || bus.op_ready !== 1'b0 || pc !== 11'h010) begin n_err++; $display("FAIL call_n2 got b=%b ready=%b pc=%h want 0/0/010", bus.bsr_branch, bus.op_ready, pc); end
        step();
        n_vec++; if (pc !== 11'h030 || bus.op_ready !== 1'b1 || depth !== 3'd1) begin n_err++; $display("FAIL call_n3 got pc=%h ready=%b depth=%0d want 030/1/1", pc, bus.op_ready, depth); end
        issue(2'(OP_RET), 10'h000);
        n_vec++; if (bus.bsr_return !== 1'b1 || bus.bsr_branch !== 1'b0 || depth !== 3'd0) begin n_err++; $display("FAIL ret_strobe got r=%b b=%b depth=%0d want 1/0/0", bus.bsr_return, bus.bsr_branch, depth); end
        n_vec++; if (bus.bsr_old_pc !== 11'h010 || bus.bsr_s !== 10'h020) begin n_err++; $display("FAIL ret_hold got old=%h s=%h want 010/020", bus.bsr_old_pc, bus.bsr_s); end
        step(); step();
        n_vec++; if (pc !== 11'h011 || bus.op_ready !== 1'b1) begin n_err++; $display("FAIL ret_pc got pc=%h ready=%b want 011/1", pc, bus.op_ready); end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            issue(2'(OP_CALL), 10'h001);
            step(); step();
        end
        n_vec++; if (depth !== 3'd4 || pc !== 11'h004) begin n_err++; $display("FAIL ovf_setup got depth=%0d pc=%h want 4/004", depth, pc); end
        issue(2'(OP_CALL), 10'h001);
        n_vec++; if (fault !== 1'b1 || bus.bsr_branch !== 1'b0) begin n_err++; $display("FAIL ovf_fault got fault=%b branch=%b want 1/0", fault, bus.bsr_branch); end
        n_vec++; if (bus.bsr_enable !== 1'b0 || bus.op_ready !== 1'b0) begin n_err++; $display("FAIL ovf_disable got en=%b ready=%b want 0/0", bus.bsr_enable, bus.op_ready); end
        n_vec++; if (pc !== 11'h004 || depth !== 3'd4) begin n_err++; $display("FAIL ovf_hold got pc=%h depth=%0d want 004/4", pc, depth); end
        issue(2'(OP_NEXT), 10'h000);
        issue(2'(OP_JUMP), 10'h055);
        issue(2'(OP_RET), 10'h000);
        n_vec++; if (pc !== 11'h004 || depth !== 3'd4 || fault !== 1'b1 || bus.bsr_return !== 1'b0) begin n_err++; $display("FAIL ovf_frozen got pc=%h depth=%0d fault=%b ret=%b want 004/4/1/0", pc, depth, fault, bus.bsr_return); end
    endtask

    task automatic test_underflow();
        do_reset();
        issue(2'(OP_RET), 10'h000);
        n_vec++; if (fault !== 1'b1 || bus.bsr_return !== 1'b0 || pc !== 11'h000 || depth !== 3'd0) begin n_err++; $display("FAIL unf_fault got fault=%b ret=%b pc=%h depth=%0d want 1/0/000/0", fault, bus.bsr_return, pc, depth); end
        do_reset();
        n_vec++; if (fault !== 1'b0 || pc !== 11'h000 || depth !== 3'd0 || bus.op_ready !== 1'b1 || bus.bsr_enable !== 1'b1) begin n_err++; $display("FAIL unf_reset got fault=%b pc=%h depth=%0d ready=%b en=%b want 0/000/0/1/1", fault, pc, depth, bus.op_ready, bus.bsr_enable); end
    endtask

    task automatic test_wrap();
        issue(2'(OP_JUMP), 10'h3FF);
        issue(2'(OP_JUMP), 10'h3FF);
        issue(2'(OP_NEXT), 10'h000);
        n_vec++; if (pc !== 11'h7FF) begin n_err++; $display("FAIL wrap_setup got=%h want=7FF", pc); end
        issue(2'(OP_JUMP), 10'h002);
        n_vec++; if (pc !== 11'h001 || fault !== 1'b0) begin n_err++; $display("FAIL wrap_jump got pc=%h fault=%b want 001/0", pc, fault); end
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        issue(2'(OP_CALL), 10'h005);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_vec++; if (pc !== 11'h000 || depth !== 3'd0 || bus.op_ready !== 1'b1) begin n_err++; $display("FAIL rstwait_state got pc=%h depth=%0d ready=%b want 000/0/1", pc, depth, bus.op_ready); end
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++; if ({bus.bsr_branch, bus.bsr_return} !== 2'b00 || pc !== 11'h000) begin n_err++; $display("FAIL rstwait_quiet[%0d] got strobes=%b pc=%h want 00/000", i, {bus.bsr_branch, bus.bsr_return}, pc); end
        end
        // Reset during the strobe cycle drops the strobe as well
        issue(2'(OP_CALL), 10'h005);
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_vec++; if (bus.bsr_branch !== 1'b0 || pc !== 11'h000 || depth !== 3'd0) begin n_err++; $display("FAIL rststrobe got branch=%b pc=%h depth=%0d want 0/000/0", bus.bsr_branch, pc, depth); end
    endtask

    task automatic test_back_to_back();
        issue(2'(OP_NEXT), 10'h000);
        issue(2'(OP_JUMP), 10'h010);
        issue(2'(OP_NEXT), 10'h000);
        n_vec++; if (pc !== 11'h012 || bus.op_ready !== 1'b1) begin n_err++; $display("FAIL b2b got pc=%h ready=%b want 012/1", pc, bus.op_ready); end
    endtask

    initial begin
        n_vec         = 0;
        n_err         = 0;
        reset         = 1'b1;
        bus.op_valid  = 1'b0;
        bus.op_code   = 2'b00;
        bus.op_offset = '0;
        test_reset();
        test_next();
        test_call_ret();
        test_overflow();
        test_underflow();
        test_wrap();
        test_reset_in_wait();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer that drives the branch/subroutine return stack (BSR) from the instruction side. It accepts one control-flow op at a time, issues the single-cycle `branch`/`return` strobes, supplies `OLD_PC` and `S`, and loads the target the stack returns one clock later. It also tracks call depth itself and turns stack overflow or underflow into a sticky fault instead of corrupting the stack.

## Interface
Parameters:
- `PC_W`, 11, program-counter width; equals BSR PC width.
- `OFF_W`, 10, offset width; equals BSR `S` width.
- `DEPTH`, 4, return-stack entries; equals BSR shift-register depth.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `op_valid`  in  1  op offered this cycle.
- `op_code`  in  2  00 NEXT, 01 JUMP, 10 CALL, 11 RET.
- `op_offset`  in  OFF_W  unsigned offset for JUMP/CALL.
- `op_ready`  out  1  op accepted when `op_valid & op_ready`.
- `pc`  out  PC_W  current program counter.
- `depth`  out  3  current call depth, 0..DEPTH.
- `fault`  out  1  sticky overflow/underflow flag.
- `bsr_enable`  out  1  to BSR `enable`.
- `bsr_branch`  out  1  to BSR `branch`; one-cycle pulse.
- `bsr_return`  out  1  to BSR `return`; one-cycle pulse.
- `bsr_s`  out  OFF_W  to BSR `S`.
- `bsr_old_pc`  out  PC_W  to BSR `OLD_PC`.
- `bsr_new_pc`  in  PC_W  from BSR `NEW_PC`.

## Operation
- States: RUN, WAIT, FAULT.
- RUN: `op_ready`=1. On an accepted op:
  - NEXT: `pc <= pc+1`.
  - JUMP: `pc <= pc + zero-extended op_offset`. Both stay in RUN.
  - CALL with `depth < DEPTH`: assert `bsr_branch`, drive `bsr_old_pc=pc` and `bsr_s=op_offset`, `depth <= depth+1`, go to WAIT.
  - RET with `depth > 0`: assert `bsr_return`, `depth <= depth-1`, go to WAIT.
  - CALL with `depth == DEPTH`, or RET with `depth == 0`: no strobe, `fault <= 1`, go to FAULT. `pc` and `depth` are unchanged.
- WAIT: `op_ready`=0, no strobes. Load `pc <= bsr_new_pc`, return to RUN.
  - After a CALL, the loaded value is the old pc plus the offset.
  - After a RET, it is the saved pc plus 1.
- FAULT: `op_ready`=0, `bsr_enable`=0, no strobes, `pc` frozen. Only `reset` exits.
- `bsr_enable`=1 in RUN and WAIT.
- `bsr_s` and `bsr_old_pc` are registered copies of the op operands. They hold their value outside strobe cycles.
- Arithmetic is modulo 2^PC_W: wrap-around from 0x7FF to 0x000 is legal and is not a fault.
- `op_valid` while `op_ready`=0 is ignored; the op is not queued.

## Timing
- Reset values: `pc`=0, `depth`=0, `fault`=0, `op_ready`=1 (RUN), `bsr_branch`=0, `bsr_return`=0, `bsr_enable`=1, `bsr_s`=0, `bsr_old_pc`=0.
- NEXT/JUMP latency: 1 cycle. A back-to-back op every cycle is allowed.
- CALL/RET latency: 2 cycles.
  - Cycle N: op accepted.
  - Cycle N+1: strobe high, registered outputs valid; BSR samples on the edge ending N+1.
  - Cycle N+2: `bsr_new_pc` valid and loaded into `pc`; state WAIT.
  - Cycle N+3: new `pc` visible, `op_ready`=1.
- Strobes are registered; `bsr_branch` and `bsr_return` are never high in the same cycle.
- `reset` in any state, including WAIT or the strobe cycle, takes effect on that edge. A strobe in flight is dropped.
- The BSR has no reset, so the sequencer does not rely on its contents or its `level` output. `depth` is authoritative.

## Structure
- Shared package: the `op_code` encoding constants (NEXT/JUMP/CALL/RET), the state enum (RUN/WAIT/FAULT), and the `PC_W`/`OFF_W`/`DEPTH` defaults shared with the BSR.
- Single module, no sub-module. The bench instantiates the BSR alongside it.

## Test plan
- Reset, then NEXT ×3 -> `pc`=3, `depth`=0, `op_ready` high throughout.
- At `pc`=0x010, CALL with offset 0x020 -> `bsr_branch` pulse with `bsr_old_pc`=0x010; `pc`=0x030 two cycles later; `depth`=1.
- At that point, RET -> `bsr_return` pulse; `pc`=0x011 two cycles later; `depth`=0.
- Five nested CALLs -> the first four succeed (`depth`=4). The fifth raises `fault` with no strobe and `bsr_enable`=0. `pc` holds, and stays held through further ops.
- RET at `depth`=0 -> `fault`=1. Then `reset` -> `pc`=0, `depth`=0, `fault`=0.
- At `pc`=0x7FF, JUMP with offset 2 -> `pc`=0x001. In a separate run, assert `reset` during the WAIT cycle of a CALL -> `pc`=0 and no further strobe.
